// File: rtl/fb_pkg.sv
// fb_pkg: shared framebuffer types and constants for the plot writer.
package fb_pkg;
  localparam int FB_WORDS = 19200;
  localparam int ADDR_W = 15;
  typedef logic [2:0] colour_t;
  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    colour_t    colour;
  } pixel_t;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;
endpackage

// File: rtl/fb_plot_writer_fifo.sv
// plot_fifo: first-word-fallthrough FIFO of pixels; push while full is accepted only with a pop.
module plot_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  pixel_t din,
  input  logic   pop,
  output pixel_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  pixel_t mem_q [DEPTH];
  pixel_t mem_d [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem_q[rd_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q[AW-1:0]] = din;
    wr_d = wr_q + (AW+1)'(do_push);
    rd_d = rd_q + (AW+1)'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/fb_plot_writer.sv
// fb_plot_writer: turns pixel plots into framebuffer writes and runs a full-screen clear.
// Define FB_CLIP_EN to discard (and count) plots outside the FB_W x FB_H screen.
module fb_plot_writer
  import fb_pkg::*;
#(
  parameter int FB_W = 160,
  parameter int FB_H = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        vga_x,
  input  logic [6:0]        vga_y,
  input  logic [2:0]        vga_colour,
  input  logic              vga_plot,
  input  logic              start,
  input  logic [2:0]        clear_colour,
  output logic              done,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  output logic              mem_we,
  output logic [7:0]        drop_count
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_W * FB_H - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, addr_q, addr_d, head_addr;
  colour_t fill_q, fill_d, wdata_q, wdata_d;
  logic we_q, we_d;
  logic [7:0] drop_q, drop_d;
  pixel_t head;
  logic full, empty, push, pop, drop;
  assign pop = (state_q != CLEAR) && !empty;
`ifdef FB_CLIP_EN
  logic in_range;
  assign in_range = (32'(vga_x) < FB_W) && (32'(vga_y) < FB_H);
  assign push = vga_plot && in_range;
  assign drop = vga_plot && (!in_range || (full && !pop));
`else
  assign push = vga_plot;
  assign drop = vga_plot && full && !pop;
`endif
  plot_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  ('{x: vga_x, y: vga_y, colour: vga_colour}),
    .pop  (pop),
    .dout (head),
    .full (full),
    .empty(empty)
  );
  assign head_addr = ADDR_W'(head.y) * ADDR_W'(FB_W) + ADDR_W'(head.x);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fill_d = fill_q;
    we_d = pop;
    addr_d = pop ? head_addr : addr_q;
    wdata_d = pop ? head.colour : wdata_q;
    drop_d = (drop && drop_q != 8'hff) ? drop_q + 8'd1 : drop_q;
    unique case (state_q)
      IDLE: begin
        state_d = start ? CLEAR : IDLE;
        cnt_d = start ? '0 : cnt_q;
        fill_d = start ? clear_colour : fill_q;
      end
      CLEAR: begin
        we_d = 1'b1;
        addr_d = cnt_q;
        wdata_d = fill_q;
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == LAST) ? DONE : CLEAR;
      end
      DONE: state_d = start ? DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fill_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      drop_q <= drop_d;
    end
  end
  assign done = state_q == DONE;
  assign busy = (state_q == CLEAR) || !empty;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we = we_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_fb_plot_writer.sv
// tb_fb_plot_writer: directed and random checks of plot writes, clears, buffering and reset.
module tb_fb_plot_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] vga_x = '0;
  logic [6:0] vga_y = '0;
  logic [2:0] vga_colour = '0;
  logic vga_plot = 1'b0;
  logic start = 1'b0;
  logic [2:0] clear_colour = '0;
  logic done, busy, mem_we;
  logic [14:0] mem_addr;
  logic [2:0] mem_wdata;
  logic [7:0] drop_count;
  int n_chk = 0;
  int n_fail = 0;
  int exp_drop = 0;
  logic pv = 1'b0;
  int pa = 0;
  int pc = 0;
  int bx [7];
  int by [7];
  int bc [7];

  fb_plot_writer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .vga_colour  (vga_colour),
    .vga_plot    (vga_plot),
    .start       (start),
    .clear_colour(clear_colour),
    .done        (done),
    .busy        (busy),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_addr(input int x, input int y);
    return (y * 160 + x) % 32768;
  endfunction

  function automatic logic ref_keep(input int x, input int y);
`ifdef FB_CLIP_EN
    return x < 160 && y < 120;
`else
    return 1'b1;
`endif
  endfunction

  // Idle FIFO: each plot appears as a write exactly one edge after it is taken.
  task automatic plot_cycle(input logic v, input int x, input int y, input int c);
    vga_plot = v;
    vga_x = x[7:0];
    vga_y = y[6:0];
    vga_colour = c[2:0];
    step();
    chk("stream_we", {31'd0, mem_we}, {31'd0, pv});
    if (pv) begin
      chk("stream_addr", {17'd0, mem_addr}, pa);
      chk("stream_wdata", {29'd0, mem_wdata}, pc);
    end
    pv = v && ref_keep(x, y);
    pa = ref_addr(x, y);
    pc = c;
    if (v && !ref_keep(x, y) && exp_drop < 255) exp_drop++;
    vga_plot = 1'b0;
  endtask

  task automatic do_clear(input int cc, input logic with_plots);
    int bad = 0;
    start = 1'b1;
    clear_colour = cc[2:0];
    step();
    clear_colour = ~cc[2:0];
    chk("clr_enter_we", {31'd0, mem_we}, 0);
    chk("clr_busy", {31'd0, busy}, 1);
    chk("clr_done_low", {31'd0, done}, 0);
    for (int i = 0; i < 19200; i++) begin
      vga_plot = with_plots && i < 6;
      if (with_plots && i < 6) begin
        vga_x = bx[i][7:0];
        vga_y = by[i][6:0];
        vga_colour = bc[i][2:0];
      end
      step();
      if (mem_we !== 1'b1 || 32'(mem_addr) !== i || 32'(mem_wdata) !== (cc & 7) || done !== (i == 19199)) bad++;
      if (with_plots && i == 10) begin
        exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
        chk("buf_busy", {31'd0, busy}, 1);
        chk("buf_drop", {24'd0, drop_count}, exp_drop);
      end
    end
    vga_plot = 1'b0;
    chk("clr_seq_bad", bad, 0);
  endtask

  initial begin
    int bad;
    int found;
    int ox, oy, d;
    #3;
    chk("rst_we", {31'd0, mem_we}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_addr", {17'd0, mem_addr}, 0);
    chk("rst_wdata", {29'd0, mem_wdata}, 0);
    chk("rst_drop", {24'd0, drop_count}, 0);
    rst_n = 1'b1;
    step();
    plot_cycle(1'b1, 157, 117, 3);
    chk("single_busy", {31'd0, busy}, 1);
    plot_cycle(1'b0, 0, 0, 0);
    chk("single_addr", {17'd0, mem_addr}, 18877);
    plot_cycle(1'b0, 0, 0, 0);
    chk("single_drop", {24'd0, drop_count}, 0);

    do_clear(5, 1'b0);
    step();
    chk("done_held", {31'd0, done}, 1);
    chk("done_no_we", {31'd0, mem_we}, 0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done !== 1'b1 || mem_we !== 1'b0) bad++;
    end
    chk("done_no_retrigger", bad, 0);
    start = 1'b0;
    step();
    chk("done_release", {31'd0, done}, 0);
    chk("idle_busy", {31'd0, busy}, 0);

    for (int i = 0; i < 7; i++) begin
      bx[i] = $urandom_range(0, 159);
      by[i] = $urandom_range(0, 119);
      bc[i] = $urandom_range(0, 7);
    end
    do_clear($urandom_range(0, 7), 1'b1);
    vga_plot = 1'b1;
    vga_x = bx[6][7:0];
    vga_y = by[6][6:0];
    vga_colour = bc[6][2:0];
    for (int i = 0; i < 5; i++) begin
      int k;
      k = (i == 4) ? 6 : i;
      step();
      vga_plot = 1'b0;
      chk("drain_we", {31'd0, mem_we}, 1);
      chk("drain_addr", {17'd0, mem_addr}, ref_addr(bx[k], by[k]));
      chk("drain_wdata", {29'd0, mem_wdata}, bc[k]);
    end
    step();
    chk("drain_end_we", {31'd0, mem_we}, 0);
    chk("drain_end_busy", {31'd0, busy}, 0);
    chk("drain_drop", {24'd0, drop_count}, exp_drop);
    start = 1'b0;
    step();

    ox = 3;
    oy = 0;
    d = 1 - 3;
    while (oy <= ox) begin
      plot_cycle(1'b1, 157 + ox, 117 + oy, 2);
      plot_cycle(1'b1, 157 - ox, 117 + oy, 2);
      plot_cycle(1'b1, 157 + ox, 117 - oy, 2);
      plot_cycle(1'b1, 157 - ox, 117 - oy, 2);
      plot_cycle(1'b1, 157 + oy, 117 + ox, 2);
      plot_cycle(1'b1, 157 - oy, 117 + ox, 2);
      plot_cycle(1'b1, 157 + oy, 117 - ox, 2);
      plot_cycle(1'b1, 157 - oy, 117 - ox, 2);
      oy++;
      if (d <= 0) d += 2 * oy + 1;
      else begin
        ox--;
        d += 2 * (oy - ox) + 1;
      end
    end
    plot_cycle(1'b0, 0, 0, 0);
    chk("circle_drop", {24'd0, drop_count}, exp_drop);

    plot_cycle(1'b1, 160, 0, 1);
    plot_cycle(1'b1, 0, 120, 4);
    plot_cycle(1'b1, 159, 119, 7);
    plot_cycle(1'b0, 0, 0, 0);
    chk("clip_drop", {24'd0, drop_count}, exp_drop);

    for (int i = 0; i < 150; i++)
      plot_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 7));
    plot_cycle(1'b0, 0, 0, 0);
    chk("rand_drop", {24'd0, drop_count}, exp_drop);

    start = 1'b1;
    clear_colour = 3'd6;
    step();
    found = 0;
    for (int i = 0; i < 300 && found == 0; i++) begin
      step();
      if (mem_we === 1'b1 && mem_addr === 15'd100) found = 1;
    end
    chk("reach_addr100", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, mem_we}, 0);
    chk("arst_done", {31'd0, done}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_drop", {24'd0, drop_count}, 0);
    exp_drop = 0;
    start = 1'b0;
    step();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (mem_we !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("post_rst_quiet", bad, 0);
    plot_cycle(1'b1, 12, 34, 5);
    plot_cycle(1'b0, 0, 0, 0);
    chk("post_rst_addr", {17'd0, mem_addr}, 34 * 160 + 12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fb_plot_writer.md
Name: fb_plot_writer

Overview:
- Receiving end of the pixel-plot interface (vga_x/vga_y/vga_colour/vga_plot) driven by the drawing engines, e.g. circle.
- Turns each plot into a linear framebuffer write (160x120, 3-bit colour) on a single-port memory write interface.
- Provides a start/done full-screen clear engine; plots arriving during a clear are buffered in a small FIFO.

Parameters:
- FB_W, 160, framebuffer width in pixels
- FB_H, 120, framebuffer height in pixels
- FIFO_DEPTH, 4, plot buffer entries (power of two)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- vga_x  in  8  plot x coordinate
- vga_y  in  7  plot y coordinate
- vga_colour  in  3  plot colour
- vga_plot  in  1  plot strobe; one pixel per cycle high, no backpressure
- start  in  1  clear request (level, start/done handshake)
- clear_colour  in  3  fill colour, latched when a clear begins
- done  out  1  clear complete; held until start is deasserted
- busy  out  1  high in CLEAR, or while the FIFO is non-empty
- mem_addr  out  15  framebuffer word address
- mem_wdata  out  3  write colour
- mem_we  out  1  write enable, one word per cycle
- drop_count  out  8  saturating count of discarded plots

Behaviour:
- Reset (async, rst_n=0): state IDLE; FIFO empty; done, busy, mem_we = 0; mem_addr, mem_wdata, drop_count = 0.
- Reset mid-clear aborts the clear. No write may occur after rst_n falls.
- Address rule: y*FB_W + x = (y<<7)+(y<<5)+x, computed in 15 bits.
- Plot path:
  - vga_plot sampled high at edge k is enqueued as {x,y,colour} at edge k.
  - FIFO is first-word-fallthrough. The head is popped whenever the state is not CLEAR.
  - The registered write (mem_we=1, addr, wdata) is visible from edge k+1, so latency is 1 cycle with the FIFO empty.
  - Back-to-back plots produce back-to-back writes.
  - Simultaneous enqueue and pop at a full FIFO is accepted.
  - Enqueue while full with no pop drops the pixel and increments drop_count (saturates at 255).
- State machine IDLE -> CLEAR -> DONE -> IDLE:
  - IDLE: start=1 at an edge latches clear_colour, clears the counter to 0 and enters CLEAR. A FIFO pop at that same edge still issues its write, and clear writes follow it (the pixel is overwritten, as intended).
  - CLEAR: one write per cycle, addr 0..FB_W*FB_H-1 (0..19199), wdata = latched colour. Plots are enqueued only. Enter DONE after the write of addr 19199; done=1 from that edge.
  - DONE: done stays 1 while start=1, with no re-trigger. start=0 at an edge returns to IDLE with done=0. The FIFO drains in DONE and IDLE.
- Clear duration: exactly 19200 consecutive mem_we cycles, mem_we=1 throughout.
- mem_we=0 on any cycle with no write. mem_addr/mem_wdata hold their last value.
- Write ordering: writes appear in enqueue order. Clear writes are never interleaved with plot writes.
- busy = (state==CLEAR) || !fifo_empty.

Optional Feature:
- Macro FB_CLIP_EN.
  - Defined: plots with x>=FB_W or y>=FB_H are discarded at input, never enqueued, and increment drop_count.
  - Undefined: no range check. Out-of-range plots are written at the address given by the rule above, truncated to 15 bits.

Decomposition:
- Package fb_pkg:
  - FB_WORDS=19200, ADDR_W=15
  - typedef colour_t (logic [2:0])
  - struct pixel_t {x[7:0], y[6:0], colour_t}
  - enum state_t {IDLE, CLEAR, DONE}
- Sub-module plot_fifo: parameterised FWFT FIFO of pixel_t with push, pop, full and empty.

Test Plan:
- Reset, then single plot (157,117,colour 3) -> exactly one mem_we cycle one edge later, addr 18877, wdata 3; drop_count 0.
- start=1, clear_colour=5 -> 19200 consecutive writes, addr 0..19199, wdata 5. done=1 after the last write and held while start=1. start=0 -> done=0 at the next edge. start=1 again -> new clear from addr 0.
- Six plots during CLEAR -> four buffered, drop_count=2, busy=1. After DONE, four writes in enqueue order on consecutive cycles.
- Radius-3 circle from circle at (157,117), plots streamed back-to-back -> one write per plot, latency 1, addresses match the rule.
- FB_CLIP_EN defined, plots (160,0), (0,120), (159,119) -> first two not written, drop_count=2, third writes addr 19199. Macro undefined -> (160,0) writes addr 160.
- rst_n low at clear addr 100 -> mem_we=0 immediately (async), done=0, state IDLE. After release, no writes until the next plot or start.
